// File: rtl/ll_resp_pkg.sv
// Shared types for the linked-list response path: response codes, scheduler
// FSM states and the default-width packed response word.
package ll_resp_pkg;

  typedef enum logic [2:0] {
    RESP_NONE       = 3'd0,
    RESP_TOT_NODES  = 3'd1,
    RESP_LL_NODES   = 3'd2,
    RESP_NO_OP      = 3'd3,
    RESP_DONE       = 3'd4,
    RESP_DECODE_ERR = 3'd5
  } resp_code_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  localparam int LL_NODENUM_WIDTH      = 8;
  localparam int LL_HEADPTR_ADDR_WIDTH = 4;

  typedef struct packed {
    resp_code_e                       code;
    logic [LL_HEADPTR_ADDR_WIDTH-1:0] ll_num;
    logic [LL_NODENUM_WIDTH-1:0]      num_nodes;
  } resp_word_t;

  // RESP_NONE and the unassigned encodings 6/7 are not valid responses.
  function automatic resp_code_e sanitize_code(input logic [2:0] raw);
    if (raw >= 3'd1 && raw <= 3'd5) begin
      return resp_code_e'(raw);
    end
    return RESP_DECODE_ERR;
  endfunction

endpackage

// File: rtl/ll_rr_arb.sv
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping modulo N. Shared by the linked-list arbiters.
module ll_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  always_comb begin
    int idx;
    o_winner = '0;
    o_any    = |i_req;
    // Walk from the farthest offset down so the nearest request wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (i_req[idx]) begin
        o_winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ll_resp_sched.sv
// Round-robin response scheduler with a holding register and valid/ready output.
// Optional stall timeout enabled by defining LL_RESP_TIMEOUT_EN.
module ll_resp_sched
  import ll_resp_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int NODENUM_WIDTH      = 8,
  parameter int HEADPTR_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_REQ-1:0]                         i_req_vld,
  input  logic [3*NUM_REQ-1:0]                       i_req_code,
  input  logic [HEADPTR_ADDR_WIDTH*NUM_REQ-1:0]      i_req_ll_num,
  input  logic [NODENUM_WIDTH*NUM_REQ-1:0]           i_req_num_nodes,
  output logic [NUM_REQ-1:0]                         o_req_taken,
  output logic [NUM_REQ-1:0]                         o_req_cmpltd,
  output logic                                       o_resp_vld,
  input  logic                                       i_resp_rdy,
  output logic [3+HEADPTR_ADDR_WIDTH+NODENUM_WIDTH-1:0] o_resp_data,
  output logic [$clog2(NUM_REQ)-1:0]                 o_resp_src,
  output logic                                       o_timeout_err
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef struct packed {
    resp_code_e                    code;
    logic [HEADPTR_ADDR_WIDTH-1:0] ll_num;
    logic [NODENUM_WIDTH-1:0]      num_nodes;
  } hold_t;

  logic [2:0]                    w_code_arr  [NUM_REQ];
  logic [HEADPTR_ADDR_WIDTH-1:0] w_ll_arr    [NUM_REQ];
  logic [NODENUM_WIDTH-1:0]      w_nodes_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_code_arr[gi]  = i_req_code[3*gi +: 3];
      assign w_ll_arr[gi]    = i_req_ll_num[HEADPTR_ADDR_WIDTH*gi +: HEADPTR_ADDR_WIDTH];
      assign w_nodes_arr[gi] = i_req_num_nodes[NODENUM_WIDTH*gi +: NODENUM_WIDTH];
    end
  endgenerate

  sched_state_e       r_state;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_src;
  hold_t              r_hold;
  logic [NUM_REQ-1:0] r_taken;
  logic [NUM_REQ-1:0] r_cmpltd;
  logic               r_vld;
  logic               r_timeout_err;

  logic [SRC_W-1:0]   w_winner;
  logic               w_any_req;
  logic [SRC_W-1:0]   w_next_ptr;

  ll_rr_arb #(
    .N  (NUM_REQ),
    .IW (SRC_W)
  ) u_arb (
    .i_req    (i_req_vld),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any_req)
  );

  assign w_next_ptr = (w_winner == SRC_W'(NUM_REQ - 1)) ? '0 : w_winner + SRC_W'(1);

`ifdef LL_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_stall_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_src         <= '0;
      r_hold        <= '0;
      r_taken       <= '0;
      r_cmpltd      <= '0;
      r_vld         <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef LL_RESP_TIMEOUT_EN
      r_stall_cnt   <= '0;
`endif
    end else begin
      r_taken  <= '0;
      r_cmpltd <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_hold.code      <= sanitize_code(w_code_arr[w_winner]);
            r_hold.ll_num    <= w_ll_arr[w_winner];
            r_hold.num_nodes <= w_nodes_arr[w_winner];
            r_src            <= w_winner;
            r_taken          <= NUM_REQ'(1) << w_winner;
            r_vld            <= 1'b1;
            r_rr_ptr         <= w_next_ptr;
            r_state          <= SEND;
`ifdef LL_RESP_TIMEOUT_EN
            r_stall_cnt      <= '0;
`endif
          end
        end
        SEND: begin
          // r_vld is always set in SEND, so ready alone completes the handshake.
          if (i_resp_rdy) begin
            r_cmpltd <= NUM_REQ'(1) << r_src;
            r_vld    <= 1'b0;
            r_state  <= IDLE;
          end
`ifdef LL_RESP_TIMEOUT_EN
          else if (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cmpltd      <= NUM_REQ'(1) << r_src;
            r_vld         <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_taken   = r_taken;
  assign o_req_cmpltd  = r_cmpltd;
  assign o_resp_vld    = r_vld;
  assign o_resp_data   = r_hold;
  assign o_resp_src    = r_src;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ll_resp_sched.sv
// Directed bench for ll_resp_sched; covers the timeout path when built with
// LL_RESP_TIMEOUT_EN.
module tb_ll_resp_sched;

  localparam int NR = 4;
  localparam int NW = 8;
  localparam int HW = 4;
`ifdef LL_RESP_TIMEOUT_EN
  localparam int TO    = 8;
  localparam int STALL = 5;
`else
  localparam int TO    = 255;
  localparam int STALL = 10;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_vld = '0;
  logic [3*NR-1:0]   req_code = '0;
  logic [HW*NR-1:0]  req_ll_num = '0;
  logic [NW*NR-1:0]  req_num_nodes = '0;
  logic [NR-1:0]     req_taken;
  logic [NR-1:0]     req_cmpltd;
  logic              resp_vld;
  logic              resp_rdy = 1'b0;
  logic [3+HW+NW-1:0] resp_data;
  logic [1:0]        resp_src;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ll_resp_sched #(
    .NUM_REQ            (NR),
    .NODENUM_WIDTH      (NW),
    .HEADPTR_ADDR_WIDTH (HW),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_req_vld       (req_vld),
    .i_req_code      (req_code),
    .i_req_ll_num    (req_ll_num),
    .i_req_num_nodes (req_num_nodes),
    .o_req_taken     (req_taken),
    .o_req_cmpltd    (req_cmpltd),
    .o_resp_vld      (resp_vld),
    .i_resp_rdy      (resp_rdy),
    .o_resp_data     (resp_data),
    .o_resp_src      (resp_src),
    .o_timeout_err   (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c,
                         input logic [HW-1:0] ll, input logic [NW-1:0] n);
    req_vld[i]              = v;
    req_code[3*i +: 3]      = c;
    req_ll_num[HW*i +: HW]  = ll;
    req_num_nodes[NW*i +: NW] = n;
  endtask

  function automatic logic [31:0] word(input int c, input int l, input int n);
    return 32'((c << 12) | (l << 8) | n);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    req_vld  = '0;
    resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_vld",    32'(resp_vld), 0);
    check_eq("rst_taken",  32'(req_taken), 0);
    check_eq("rst_cmpltd", 32'(req_cmpltd), 0);
    check_eq("rst_data",   32'(resp_data), 0);
    check_eq("rst_src",    32'(resp_src), 0);
    check_eq("rst_err",    32'(timeout_err), 0);
    reset_n = 1'b1;
  endtask

  initial begin
    // Single request from requester 1
    do_reset();
    set_req(1, 1'b1, 3'd1, 4'd3, 8'd17);
    resp_rdy = 1'b1;
    @(negedge clk);
    check_eq("s1_taken", 32'(req_taken), 32'b0010);
    check_eq("s1_vld",   32'(resp_vld), 1);
    check_eq("s1_data",  32'(resp_data), word(1, 3, 17));
    check_eq("s1_src",   32'(resp_src), 1);
    check_eq("s1_nocmp", 32'(req_cmpltd), 0);
    set_req(1, 1'b0, 3'd1, 4'd3, 8'd17);
    @(negedge clk);
    check_eq("s1_cmpltd", 32'(req_cmpltd), 32'b0010);
    check_eq("s1_vld0",   32'(resp_vld), 0);
    check_eq("s1_taken0", 32'(req_taken), 0);

    // All four held from reset: grants 0,1,2,3,0 two cycles apart
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 3'(i + 1), 4'(i), 8'(10 + i));
    resp_rdy = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      check_eq($sformatf("rr%0d_taken", g), 32'(req_taken), 32'(1 << (g % 4)));
      check_eq($sformatf("rr%0d_src", g),   32'(resp_src), 32'(g % 4));
      check_eq($sformatf("rr%0d_data", g),  32'(resp_data), word((g % 4) + 1, g % 4, 10 + (g % 4)));
      @(negedge clk);
      check_eq($sformatf("rr%0d_cmpltd", g), 32'(req_cmpltd), 32'(1 << (g % 4)));
      check_eq($sformatf("rr%0d_taken0", g), 32'(req_taken), 0);
    end
    req_vld = '0;

    // Backpressure with payload change after capture
    resp_rdy = 1'b0;
    set_req(3, 1'b1, 3'd2, 4'd5, 8'd200);
    @(negedge clk);
    check_eq("bp_taken", 32'(req_taken), 32'b1000);
    set_req(3, 1'b0, 3'd4, 4'd9, 8'd1);
    for (int c = 0; c < STALL; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp%0d_vld", c),  32'(resp_vld), 1);
      check_eq($sformatf("bp%0d_data", c), 32'(resp_data), word(2, 5, 200));
      check_eq($sformatf("bp%0d_cmp", c),  32'(req_cmpltd), 0);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    check_eq("bp_cmpltd", 32'(req_cmpltd), 32'b1000);
    check_eq("bp_vld0",   32'(resp_vld), 0);
    check_eq("bp_err",    32'(timeout_err), 0);

    // Illegal codes 7 and 0 become RESP_DECODE_ERR
    set_req(2, 1'b1, 3'd7, 4'd6, 8'd60);
    @(negedge clk);
    check_eq("ill7_taken", 32'(req_taken), 32'b0100);
    check_eq("ill7_data",  32'(resp_data), word(5, 6, 60));
    check_eq("ill7_src",   32'(resp_src), 2);
    set_req(2, 1'b0, 3'd7, 4'd6, 8'd60);
    @(negedge clk);
    check_eq("ill7_cmpltd", 32'(req_cmpltd), 32'b0100);
    set_req(0, 1'b1, 3'd0, 4'd15, 8'd255);
    @(negedge clk);
    check_eq("ill0_taken", 32'(req_taken), 32'b0001);
    check_eq("ill0_data",  32'(resp_data), word(5, 15, 255));
    set_req(0, 1'b0, 3'd0, 4'd15, 8'd255);
    @(negedge clk);
    check_eq("ill0_cmpltd", 32'(req_cmpltd), 32'b0001);

    // Reset in SEND discards the response without completion
    resp_rdy = 1'b0;
    set_req(1, 1'b1, 3'd3, 4'd2, 8'd5);
    @(negedge clk);
    check_eq("mr_vld",   32'(resp_vld), 1);
    check_eq("mr_taken", 32'(req_taken), 32'b0010);
    set_req(1, 1'b0, 3'd3, 4'd2, 8'd5);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mr_vld0",   32'(resp_vld), 0);
    check_eq("mr_taken0", 32'(req_taken), 0);
    check_eq("mr_cmp0",   32'(req_cmpltd), 0);
    check_eq("mr_data0",  32'(resp_data), 0);
    check_eq("mr_src0",   32'(resp_src), 0);
    reset_n  = 1'b1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check_eq("mr_post_cmp", 32'(req_cmpltd), 0);
    check_eq("mr_post_vld", 32'(resp_vld), 0);

`ifdef LL_RESP_TIMEOUT_EN
    // Stall timeout, then normal service resumes
    resp_rdy = 1'b0;
    set_req(0, 1'b1, 3'd4, 4'd1, 8'd2);
    @(negedge clk);
    check_eq("to_vld", 32'(resp_vld), 1);
    set_req(0, 1'b0, 3'd4, 4'd1, 8'd2);
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      check_eq($sformatf("to%0d_vld", c), 32'(resp_vld), 1);
      check_eq($sformatf("to%0d_err", c), 32'(timeout_err), 0);
    end
    @(negedge clk);
    check_eq("to_vld0",   32'(resp_vld), 0);
    check_eq("to_err",    32'(timeout_err), 1);
    check_eq("to_cmpltd", 32'(req_cmpltd), 32'b0001);
    resp_rdy = 1'b1;
    set_req(1, 1'b1, 3'd1, 4'd1, 8'd1);
    @(negedge clk);
    check_eq("to_next_taken", 32'(req_taken), 32'b0010);
    set_req(1, 1'b0, 3'd1, 4'd1, 8'd1);
    @(negedge clk);
    check_eq("to_next_cmpltd", 32'(req_cmpltd), 32'b0010);
    check_eq("to_err_sticky",  32'(timeout_err), 1);
`else
    check_eq("no_timeout_err", 32'(timeout_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ll_resp_sched.md
Name: ll_resp_sched

Overview:
- Response scheduler in front of the linked-list response path.
- Arbitrates round-robin among NUM_REQ response requesters (ll_mngr instances / command ports) and captures the winner's response fields into a holding register.
- Presents the held response as one packed word on a valid/ready output stream, and returns per-requester "taken" and "completed" pulses.
- Replaces the ad-hoc "request -> taken/cmpltd next cycle" behaviour with real sequencing and backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NODENUM_WIDTH, 8, width of the node-count field
- HEADPTR_ADDR_WIDTH, 4, width of the linked-list number field
- TIMEOUT_CYCLES, 255, stall limit; used only with LL_RESP_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- req_vld  in  NUM_REQ  per-requester response request; held until its req_taken pulse
- req_code  in  3*NUM_REQ  per-requester response code (ll_resp_pkg enum), slice i = [3i+2:3i]
- req_ll_num  in  HEADPTR_ADDR_WIDTH*NUM_REQ  per-requester linked-list number
- req_num_nodes  in  NODENUM_WIDTH*NUM_REQ  per-requester node count
- req_taken  out  NUM_REQ  one-hot 1-cycle pulse: request captured
- req_cmpltd  out  NUM_REQ  one-hot 1-cycle pulse: response accepted downstream
- resp_vld  out  1  output response valid
- resp_rdy  in  1  downstream ready
- resp_data  out  3+HEADPTR_ADDR_WIDTH+NODENUM_WIDTH  {code, ll_num, num_nodes}
- resp_src  out  $clog2(NUM_REQ)  index of the requester owning resp_data
- timeout_err  out  1  sticky stall-timeout flag; tied 0 when the feature is absent

Behaviour:
- Reset:
  - state=IDLE; rr_ptr=0
  - req_taken, req_cmpltd, resp_vld, timeout_err = 0
  - resp_data, resp_src = 0
- State IDLE: resp_vld=0.
  - If |req_vld, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Capture the winner's code, ll_num and num_nodes into the hold register; resp_src=winner.
  - Next cycle: req_taken[winner]=1, state=SEND.
  - rr_ptr=(winner+1) mod NUM_REQ.
- State SEND: resp_vld=1; resp_data and resp_src stay stable.
  - No arbitration occurs in SEND.
  - On resp_vld & resp_rdy: next cycle req_cmpltd[resp_src]=1, resp_vld=0, state=IDLE.
- Latency: req_vld sampled in IDLE at cycle N -> req_taken and resp_vld high at N+1.
  - If resp_rdy=1 at N+1: req_cmpltd at N+2, and the next arbitration is sampled at N+2.
  - Peak throughput: 1 response per 2 cycles.
- Requester contract: drop req_vld (or present a new request) in the cycle after req_taken. The hold register makes payload changes after capture harmless.
- Illegal codes (0, 6, 7): forwarded with the code field replaced by RESP_DECODE_ERR (5); ll_num and num_nodes pass unchanged.
- Simultaneous requests: exactly one grant per arbitration. Losers stay pending and are served in rotating order; no requester waits more than NUM_REQ grants.
- resp_rdy high while resp_vld=0: ignored.
- Reset mid-SEND: response discarded, no req_cmpltd pulse; the requester reissues.

Optional Feature:
- Macro: LL_RESP_TIMEOUT_EN
- Defined:
  - A stall counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering SEND and increments each SEND cycle with resp_rdy=0.
  - On reaching TIMEOUT_CYCLES: drop the response, set timeout_err (sticky until reset), pulse req_cmpltd[resp_src], return to IDLE.
  - A handshake in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; SEND waits indefinitely; timeout_err tied 0.

Decomposition:
- ll_resp_pkg holds:
  - the response-code typedef enum logic [2:0]: RESP_NONE=0, RESP_TOT_NODES=1, RESP_LL_NODES=2, RESP_NO_OP=3, RESP_DONE=4, RESP_DECODE_ERR=5
  - the FSM state typedef (IDLE, SEND)
  - a packed resp_word_t struct {code, ll_num, num_nodes}
- Sub-module: ll_rr_arb (combinational round-robin pick from req vector and rr_ptr, outputs winner index plus any_req). Reused by other linked-list arbiters.

Test Plan:
- Single request: req_vld=4'b0010, code=1, ll_num=3, num_nodes=8'd17, resp_rdy=1 -> req_taken=0010 at N+1; resp_data={1,3,17}, resp_src=1; req_cmpltd=0010 at N+2.
- All four requesters held continuously from reset -> grants in order 0,1,2,3,0; each req_taken is one-hot, 2 cycles apart.
- Backpressure: resp_rdy=0 for 10 cycles in SEND while the requester changes its payload -> resp_vld and resp_data stable; completion 1 cycle after resp_rdy rises.
- Illegal code 7 from requester 2 -> resp_data code=5, other fields unchanged.
- Reset asserted during SEND -> next cycle all outputs 0, state IDLE, no req_cmpltd.
- With LL_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, resp_rdy=0 -> after 8 stall cycles timeout_err=1, req_cmpltd pulses, and the next request is still served.
